// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and constants for the 1-to-2 stream demux
package stream_demux_pkg;

    typedef enum logic {IDLE, LOCKED} demux_state_t;

    typedef logic chan_t;

    localparam int NUM_CH = 2;

endpackage

// File: rtl/demux_out_slice.sv
// rtl/demux_out_slice.sv - one-entry output register stage for a single demux channel
module demux_out_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              valid
);

    // A load in the same cycle as a drain wins: the new beat replaces the departing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            last  <= load_last;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1x2.sv
// rtl/stream_demux_1x2.sv - registered 1-to-2 packet demux with per-packet route lock
module stream_demux_1x2
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [DATA_W-1:0] d_in,
    input  logic              sel_in,
    input  logic              valid_in,
    input  logic              last_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] d0_out,
    output logic [DATA_W-1:0] d1_out,
    output logic              valid0_out,
    output logic              valid1_out,
    output logic              last0_out,
    output logic              last1_out,
    input  logic              ready0_in,
    input  logic              ready1_in
);

    demux_state_t      state;
    chan_t             route_q;
    chan_t             route;
    logic              acc;

    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_last;
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] ch_load;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    assign ch_ready = {ready1_in, ready0_in};

    // The first beat of a packet steers by sel_in directly; later beats follow the latched route.
    assign route     = (state == IDLE) ? sel_in : route_q;
    assign ready_out = ~ch_valid[route] | ch_ready[route];
    assign acc       = valid_in & ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            route_q <= 1'b0;
        end else if (acc) begin
            if (state == IDLE) begin
                if (!last_in) begin
                    state   <= LOCKED;
                    route_q <= sel_in;
                end
            end else if (last_in) begin
                state <= IDLE;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_load[k] = acc & (route == chan_t'(k));

        demux_out_slice #(
            .DATA_W(DATA_W)
        ) u_slice (
            .clk       (clk_in),
            .rst_n     (rst_n_in),
            .load      (ch_load[k]),
            .load_data (d_in),
            .load_last (last_in),
            .ready     (ch_ready[k]),
            .data      (ch_data[k]),
            .last      (ch_last[k]),
            .valid     (ch_valid[k])
        );
    end

    assign d0_out     = ch_data[0];
    assign d1_out     = ch_data[1];
    assign valid0_out = ch_valid[0];
    assign valid1_out = ch_valid[1];
    assign last0_out  = ch_last[0];
    assign last1_out  = ch_last[1];

endmodule

// File: tb/tb_stream_demux_1x2.sv
// tb/tb_stream_demux_1x2.sv - scoreboard bench for stream_demux_1x2
module tb_stream_demux_1x2;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [7:0] d_in;
    logic       sel_in;
    logic       valid_in;
    logic       last_in;
    logic       ready_out;
    logic [7:0] d0_out;
    logic [7:0] d1_out;
    logic       valid0_out;
    logic       valid1_out;
    logic       last0_out;
    logic       last1_out;
    logic       ready0_in;
    logic       ready1_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         acc_cyc;
        bit         timed;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    stream_demux_1x2 #(.DATA_W(8)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .d_in       (d_in),
        .sel_in     (sel_in),
        .valid_in   (valid_in),
        .last_in    (last_in),
        .ready_out  (ready_out),
        .d0_out     (d0_out),
        .d1_out     (d1_out),
        .valid0_out (valid0_out),
        .valid1_out (valid1_out),
        .last0_out  (last0_out),
        .last1_out  (last1_out),
        .ready0_in  (ready0_in),
        .ready1_in  (ready1_in)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, then record its expected destination.
    task automatic send(input logic sel, input logic [7:0] data, input logic last,
                        input int chan, input bit timed);
        exp_t e;
        int   n;
        valid_in = 1'b1;
        sel_in   = sel;
        d_in     = data;
        last_in  = last;
        n = 0;
        forever begin
            @(negedge clk_in);
            if (ready_out) break;
            n++;
            if (n >= 50) begin
                check("accept_timeout", 0, 1);
                @(posedge clk_in); #1;
                valid_in = 1'b0;
                return;
            end
        end
        e.data    = data;
        e.last    = last;
        e.acc_cyc = cyc;
        e.timed   = timed;
        if (chan == 0) q0.push_back(e);
        else           q1.push_back(e);
        @(posedge clk_in); #1;
        valid_in = 1'b0;
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in === 1'b1) begin
            if (valid0_out && ready0_in) begin
                if (q0.size() == 0) begin
                    check("ch0_unexpected_beat", int'(d0_out), -1);
                end else begin
                    e = q0.pop_front();
                    check("ch0_data", int'(d0_out), int'(e.data));
                    check("ch0_last", int'(last0_out), int'(e.last));
                    if (e.timed) check("ch0_latency", cyc - e.acc_cyc, 1);
                end
            end
            if (valid1_out && ready1_in) begin
                if (q1.size() == 0) begin
                    check("ch1_unexpected_beat", int'(d1_out), -1);
                end else begin
                    e = q1.pop_front();
                    check("ch1_data", int'(d1_out), int'(e.data));
                    check("ch1_last", int'(last1_out), int'(e.last));
                    if (e.timed) check("ch1_latency", cyc - e.acc_cyc, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in  = 1'b0;
        d_in      = 8'h00;
        sel_in    = 1'b0;
        valid_in  = 1'b0;
        last_in   = 1'b0;
        ready0_in = 1'b1;
        ready1_in = 1'b1;

        // Reset state before any clock edge
        #3;
        check("rst_valid0", int'(valid0_out), 0);
        check("rst_valid1", int'(valid1_out), 0);
        check("rst_last0",  int'(last0_out), 0);
        check("rst_last1",  int'(last1_out), 0);
        check("rst_d0",     int'(d0_out), 0);
        check("rst_d1",     int'(d1_out), 0);
        check("rst_ready",  int'(ready_out), 1);
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        @(negedge clk_in);
        check("post_rst_ready", int'(ready_out), 1);
        @(posedge clk_in); #1;

        // Streaming to channel 0
        send(1'b0, 8'h11, 1'b0, 0, 1'b1);
        send(1'b0, 8'h22, 1'b0, 0, 1'b1);
        send(1'b0, 8'h33, 1'b1, 0, 1'b1);
        repeat (2) @(posedge clk_in); #1;

        // Route lock: sel toggles after the first beat
        send(1'b1, 8'h41, 1'b0, 1, 1'b1);
        send(1'b0, 8'h42, 1'b0, 1, 1'b1);
        send(1'b0, 8'h43, 1'b1, 1, 1'b1);
        repeat (2) @(posedge clk_in); #1;

        // Backpressure isolation
        ready1_in = 1'b0;
        send(1'b1, 8'hAA, 1'b1, 1, 1'b0);
        send(1'b0, 8'h55, 1'b1, 0, 1'b1);
        valid_in = 1'b1;
        sel_in   = 1'b1;
        d_in     = 8'h77;
        last_in  = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            check("bp_ready_low", int'(ready_out), 0);
            check("bp_hold_valid1", int'(valid1_out), 1);
            check("bp_hold_d1", int'(d1_out), 8'hAA);
        end
        @(posedge clk_in); #1;
        ready1_in = 1'b1;
        send(1'b1, 8'h77, 1'b1, 1, 1'b0);
        repeat (2) @(posedge clk_in); #1;

        // Back-to-back single-beat packets, alternating channels
        send(1'b0, 8'h01, 1'b1, 0, 1'b1);
        send(1'b1, 8'h02, 1'b1, 1, 1'b1);
        send(1'b0, 8'h03, 1'b1, 0, 1'b1);
        send(1'b1, 8'h04, 1'b1, 1, 1'b1);
        repeat (2) @(posedge clk_in); #1;

        // Mid-packet reset on a channel 1 packet
        send(1'b1, 8'hB0, 1'b0, 1, 1'b1);
        send(1'b1, 8'hB1, 1'b0, 1, 1'b1);
        ready1_in = 1'b0;
        check("pre_rst_valid1", int'(valid1_out), 1);
        rst_n_in = 1'b0;
        #1;
        check("async_rst_valid0", int'(valid0_out), 0);
        check("async_rst_valid1", int'(valid1_out), 0);
        check("async_rst_ready",  int'(ready_out), 1);
        void'(q1.pop_back());
        @(posedge clk_in); #1;
        rst_n_in  = 1'b1;
        ready1_in = 1'b1;
        @(posedge clk_in); #1;
        send(1'b0, 8'hC1, 1'b0, 0, 1'b1);
        send(1'b1, 8'hC2, 1'b1, 0, 1'b1);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_1x2.md
# stream_demux_1x2

Registered 1-to-2 stream demultiplexer: routes each packet on a single valid/ready input stream to one of two output channels, chosen by `sel_in` on the packet's first beat. It is the receive-side counterpart of the 2:1 mux datapath and splits a merged stream back into per-channel streams. Each output has a one-entry register stage, so the outputs drain independently under backpressure.

## Interface
- `DATA_W`, default 8: payload width in bits.

- `clk_in`  input  1  single clock; all state updates on the rising edge.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `d_in`  input  DATA_W  input payload.
- `sel_in`  input  1  destination channel; sampled only on a packet's first beat.
- `valid_in`  input  1  input beat valid.
- `last_in`  input  1  final beat of the packet.
- `ready_out`  output  1  demux can accept the input beat.
- `d0_out` / `d1_out`  output  DATA_W  channel 0/1 payload.
- `valid0_out` / `valid1_out`  output  1  channel 0/1 beat valid.
- `last0_out` / `last1_out`  output  1  channel 0/1 end of packet.
- `ready0_in` / `ready1_in`  input  1  channel 0/1 downstream ready.

## Operation
- Accept condition: `acc = valid_in & ready_out`.
- Output transfer on channel k: `valid_k_out & ready_k_in`.
- FSM has two states:
  - IDLE: the route is `sel_in` combinationally. An accepted beat with `last_in=0` latches `route_q = sel_in` and moves to LOCKED. An accepted beat with `last_in=1` (single-beat packet) stays in IDLE.
  - LOCKED: the route is `route_q` and `sel_in` is ignored. An accepted beat with `last_in=1` returns to IDLE.
- `ready_out = ~valid_r_out | ready_r_in`, where r is the current route. The unrouted channel's state never affects `ready_out`.
- Channel k register update, per cycle:
  - Load (acc and route==k): `d_k <= d_in`, `last_k <= last_in`, `valid_k <= 1`.
  - Else, if a transfer occurs on channel k: `valid_k <= 0`. Data and last hold.
  - Otherwise: hold.
- The unrouted channel drains independently of the routed one.
- Reset values of all outputs:
  - `valid0_out`, `valid1_out`, `last0_out`, `last1_out` = 0.
  - `d0_out`, `d1_out` = 0.
  - `ready_out` = 1, since both channels are empty after reset.
- Internal reset values: FSM = IDLE, `route_q` = 0.

## Timing
- Latency: a beat accepted at edge N appears as `valid_k_out=1` after edge N, i.e. one cycle.
- Throughput: 1 beat/cycle to a channel whose `ready_k_in` is held high.
- `ready_out` is combinational from `ready_r_in`, `valid_r_out`, the FSM state and, in IDLE, `sel_in`. No combinational path exists from `d_in` or `valid_in` to any output.
- Output rule: while `valid_k_out=1` and `ready_k_in=0`, `d_k_out` and `last_k_out` are stable and `valid_k_out` stays high.
- Input rule: upstream holds `d_in`, `sel_in` and `last_in` stable while `valid_in=1` and `ready_out=0`. `valid_in` must not depend on `ready_out`.
- Simultaneous load and drain on the same channel: the load wins, `valid_k` stays 1 and the new data replaces the old.
- Reset asserted mid-packet: outputs clear immediately, without waiting for a clock edge. The partial packet is discarded and the next accepted beat is treated as a first beat.

## Structure
- Package `stream_demux_pkg` contains:
  - `typedef enum logic {IDLE, LOCKED} demux_state_t`
  - `typedef logic chan_t`
  - `localparam int NUM_CH = 2`
- Sub-module `demux_out_slice` is the one-entry register stage: load/drain logic plus data/last/valid registers. It is instantiated once per channel, with `DATA_W` passed through.
- The top level contains the FSM, the route mux for `ready_out`, and the load-enable decode.

## Test plan
- Reset with `ready0_in=ready1_in=1`: all `valid*_out=0` and `ready_out=1` before any clock edge; after reset release, `ready_out=1`.
- Streaming to channel 0:
  - Stimulus: 3-beat packet `sel_in=0`, data `8'h11, 8'h22, 8'h33`, `last` on the third beat, `ready0_in=1`.
  - Response: `d0_out` shows 11, 22, 33 on consecutive cycles starting one cycle after the first accept; `last0_out=1` only with 33; `valid1_out` stays 0.
- Routing lock:
  - Stimulus: 3-beat packet with `sel_in=1` on beat 0, then toggling to 0 on beats 1–2.
  - Response: all three beats appear on channel 1 and none on channel 0.
- Backpressure isolation:
  - Stimulus: `ready1_in=0` with `8'hAA` held in channel 1; send single-beat packet `8'h55` with `sel_in=0`.
  - Response: the 55 beat is accepted and appears on `d0_out`; channel 1 holds AA with `valid1_out=1`; a following beat with `sel_in=1` sees `ready_out=0` until `ready1_in` rises.
- Back-to-back single-beat packets:
  - Stimulus: beats alternating `sel_in` 0,1,0,1 with `last_in=1` on every beat, both readies high.
  - Response: each channel receives its two beats in order, one cycle after each accept, with no stall cycles.
- Mid-packet reset:
  - Stimulus: assert `rst_n_in=0` after beat 1 of a 3-beat packet to channel 1.
  - Response: all valids drop to 0 at once; after release, a beat with `sel_in=0` and `last_in=0` routes to channel 0 and locks the route there.
